// File: rtl/logic_op_pkg.sv
// rtl/logic_op_pkg.sv - op encodings and the shared bitwise operation function
package logic_op_pkg;

    localparam logic [1:0] OP_AND  = 2'd0;
    localparam logic [1:0] OP_OR   = 2'd1;
    localparam logic [1:0] OP_XOR  = 2'd2;
    localparam logic [1:0] OP_NAND = 2'd3;

    // Callers zero-extend operands to this width and truncate the result back.
    // Every op is bitwise, so the upper bits never reach the low bits.
    localparam int LOP_MAX_WIDTH = 256;

    function automatic logic [LOP_MAX_WIDTH-1:0] logic_op_f(
        input logic [1:0]               op,
        input logic [LOP_MAX_WIDTH-1:0] a,
        input logic [LOP_MAX_WIDTH-1:0] b
    );
        logic [LOP_MAX_WIDTH-1:0] y;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            default: y = ~(a & b);
        endcase
        return y;
    endfunction

endpackage

// File: rtl/logic_op_stage.sv
// rtl/logic_op_stage.sv - one valid/data register of the handshake pipeline
module logic_op_stage
    import logic_op_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             advance,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // Data only moves with a valid item, so an emptied stage keeps its last value
    // and the tail output does not toggle on bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (advance) begin
            valid <= up_valid;
            if (up_valid) begin
                data <= up_data;
            end
        end
    end

endmodule

// File: rtl/logic_op_pipe.sv
// rtl/logic_op_pipe.sv - bitwise op with combinational, registered and valid/ready pipelined outputs
module logic_op_pipe
    import logic_op_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] comb_y,
    output logic [WIDTH-1:0] reg_y,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic             busy
);

    logic [WIDTH-1:0] op_y;
    logic [DEPTH:0]   advance;
    logic [DEPTH-1:0] stage_valid;
    logic [WIDTH-1:0] stage_data [DEPTH];

    assign op_y   = WIDTH'(logic_op_f(op, LOP_MAX_WIDTH'(a), LOP_MAX_WIDTH'(b)));
    assign comb_y = op_y;

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_y <= '0;
        end else begin
            reg_y <= op_y;
        end
    end

    // Ready ripples from the tail in one cycle: a stage may take a new item when it
    // is empty or its own item moves on, which lets empty stages absorb bubbles.
    always_comb begin
        advance[DEPTH] = out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            advance[k] = ~stage_valid[k] | advance[k+1];
        end
    end

    assign in_ready = advance[0] & ~rst;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic             up_valid;
        logic [WIDTH-1:0] up_data;

        if (k == 0) begin : g_head
            assign up_valid = in_valid & in_ready;
            assign up_data  = op_y;
        end else begin : g_body
            assign up_valid = stage_valid[k-1];
            assign up_data  = stage_data[k-1];
        end

        logic_op_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .advance  (advance[k]),
            .up_valid (up_valid),
            .up_data  (up_data),
            .valid    (stage_valid[k]),
            .data     (stage_data[k])
        );
    end

    assign out_valid = stage_valid[DEPTH-1];
    assign out_y     = stage_data[DEPTH-1];
    assign out_zero  = out_valid & (out_y == '0);
    assign busy      = |stage_valid;

endmodule

// File: tb/tb_logic_op_pipe.sv
// tb/tb_logic_op_pipe.sv - randomized self-checking bench for logic_op_pipe against a queue model
module tb_logic_op_pipe;

    localparam int W = 8;
    localparam int D = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] comb_y, reg_y, out_y;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         in_ready, out_valid, out_zero, busy;

    logic_op_pipe #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .op        (op),
        .a         (a),
        .b         (b),
        .comb_y    (comb_y),
        .reg_y     (reg_y),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_zero  (out_zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] y;
        int           cyc;
    } item_t;

    item_t        exp_q[$];
    logic [W-1:0] exp_reg_y = '0;
    int           vectors = 0;
    int           miscompares = 0;
    int           cyc = 0;

    function automatic logic [W-1:0] ref_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        case (o)
            2'd0:    return x & y;
            2'd1:    return x | y;
            2'd2:    return x ^ y;
            default: return ~(x & y);
        endcase
    endfunction

    // Pipeline holds at most D items; a new one fits if there is room or the tail leaves.
    function automatic logic exp_in_ready();
        return !rst && (out_ready || exp_q.size() < D);
    endfunction

    task automatic drive(input logic r, input logic v, input logic [1:0] o,
                         input logic [W-1:0] x, input logic [W-1:0] y, input logic ordy);
        @(negedge clk);
        rst = r; in_valid = v; op = o; a = x; b = y; out_ready = ordy;
        #1;
    endtask

    task automatic tick();
        logic         acc, emit;
        logic [W-1:0] ny;
        item_t        it;
        acc  = in_valid && exp_in_ready();
        emit = out_valid && out_ready;
        ny   = ref_op(op, a, b);
        it.y   = ny;
        it.cyc = cyc;
        @(posedge clk);
        cyc++;
        if (rst) begin
            exp_q.delete();
            exp_reg_y = '0;
        end else begin
            if (emit && exp_q.size() > 0) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(it);
            exp_reg_y = ny;
        end
    endtask

    function automatic logic [W-1:0] rnd();
        return W'($urandom());
    endfunction

    task automatic test_reset();
        drive(1, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 0);
        vectors += 5;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
        if (out_y !== '0) begin miscompares++; $display("FAIL rst_out_y: got %h, required 00", out_y); end
        if (reg_y !== '0) begin miscompares++; $display("FAIL rst_reg_y: got %h, required 00", reg_y); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b, required 0", busy); end
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_in_ready: got %b, required 0", in_ready); end
        tick();
        drive(0, 1, 2'd2, rnd(), rnd(), 0);
        vectors += 2;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_release_ready: got %b, required 1", in_ready); end
        if (out_zero !== 1'b0) begin miscompares++; $display("FAIL rst_out_zero: got %b, required 0", out_zero); end
        tick();
        drive(0, 1, 2'd1, rnd(), rnd(), 0); tick();
        drive(1, 1, 2'd0, rnd(), rnd(), 1);
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL midrst_in_ready: got %b, required 0", in_ready); end
        tick();
        drive(1, 0, 2'd0, rnd(), rnd(), 1);
        vectors += 4;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_out_valid: got %b, required 0", out_valid); end
        if (out_y !== '0) begin miscompares++; $display("FAIL midrst_out_y: got %h, required 00", out_y); end
        if (reg_y !== '0) begin miscompares++; $display("FAIL midrst_reg_y: got %h, required 00", reg_y); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b, required 0", busy); end
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 2'd0, rnd(), rnd(), 1);
            vectors++;
            if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_stale: got out_valid %b, required 0", out_valid); end
            tick();
        end
    endtask

    task automatic test_ops();
        logic [W-1:0] expect_y [4];
        expect_y[0] = 8'h30; expect_y[1] = 8'hFC; expect_y[2] = 8'hCC; expect_y[3] = 8'hCF;
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 2'(i), 8'hF0, 8'h3C, 1);
            vectors++;
            if (comb_y !== expect_y[i]) begin miscompares++; $display("FAIL ops_comb_y op%0d: got %h, required %h", i, comb_y, expect_y[i]); end
            if (out_valid && out_ready) begin
                vectors++;
                if (exp_q.size() == 0 || out_y !== exp_q[0].y || cyc - exp_q[0].cyc != D) begin
                    miscompares++; $display("FAIL ops_out_y: got %h at latency %0d, required %h at %0d", out_y, (exp_q.size() > 0) ? cyc - exp_q[0].cyc : -1, (exp_q.size() > 0) ? exp_q[0].y : '0, D);
                end
            end
            tick();
            #1;
            vectors++;
            if (reg_y !== expect_y[i]) begin miscompares++; $display("FAIL ops_reg_y op%0d: got %h, required %h", i, reg_y, expect_y[i]); end
        end
        for (int i = 0; i < D + 3; i++) begin
            drive(0, 0, 2'd0, rnd(), rnd(), 1);
            if (out_valid && out_ready) begin
                vectors++;
                if (exp_q.size() == 0 || out_y !== exp_q[0].y || cyc - exp_q[0].cyc != D) begin
                    miscompares++; $display("FAIL ops_out_y: got %h at latency %0d, required %h at %0d", out_y, (exp_q.size() > 0) ? cyc - exp_q[0].cyc : -1, (exp_q.size() > 0) ? exp_q[0].y : '0, D);
                end
            end
            tick();
        end
        vectors++;
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL ops_drain: got %0d items left, required 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        int emitted = 0;
        for (int i = 0; i < 16 + D + 2; i++) begin
            drive(0, i < 16, 2'($urandom_range(0, 3)), rnd(), rnd(), 1);
            if (i < 16) begin
                vectors++;
                if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stream_in_ready: got %b, required 1", in_ready); end
            end
            if (out_valid && out_ready) begin
                vectors++;
                emitted++;
                if (exp_q.size() == 0 || out_y !== exp_q[0].y || cyc - exp_q[0].cyc != D) begin
                    miscompares++; $display("FAIL stream_out_y: got %h at latency %0d, required %h at %0d", out_y, (exp_q.size() > 0) ? cyc - exp_q[0].cyc : -1, (exp_q.size() > 0) ? exp_q[0].y : '0, D);
                end
            end
            tick();
        end
        vectors++;
        if (emitted != 16 || exp_q.size() != 0) begin miscompares++; $display("FAIL stream_count: got %0d emitted, required 16", emitted); end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < D + 2; i++) begin
            drive(0, 1, 2'($urandom_range(0, 3)), rnd(), rnd(), 0);
            vectors++;
            if (in_ready !== exp_in_ready()) begin miscompares++; $display("FAIL bp_fill_ready: got %b, required %b", in_ready, exp_in_ready()); end
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 2'($urandom_range(0, 3)), rnd(), rnd(), 0);
            vectors += 3;
            if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready: got %b, required 0", in_ready); end
            if (busy !== 1'b1) begin miscompares++; $display("FAIL bp_busy: got %b, required 1", busy); end
            if (out_valid !== 1'b1 || exp_q.size() == 0 || out_y !== exp_q[0].y) begin
                miscompares++; $display("FAIL bp_out_y_hold: got %h valid %b, required %h", out_y, out_valid, (exp_q.size() > 0) ? exp_q[0].y : '0);
            end
            tick();
        end
        for (int i = 0; i < D + 3; i++) begin
            drive(0, i == 0, 2'($urandom_range(0, 3)), rnd(), rnd(), 1);
            if (i == 0) begin
                vectors++;
                if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_resume_ready: got %b, required 1", in_ready); end
            end
            if (out_valid && out_ready) begin
                vectors++;
                if (exp_q.size() == 0 || out_y !== exp_q[0].y) begin
                    miscompares++; $display("FAIL bp_drain_y: got %h, required %h", out_y, (exp_q.size() > 0) ? exp_q[0].y : '0);
                end
            end
            tick();
        end
        #1;
        vectors++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin miscompares++; $display("FAIL bp_drain_empty: got %0d left busy %b, required 0 left busy 0", exp_q.size(), busy); end
    endtask

    task automatic test_bubble();
        drive(0, 1, 2'($urandom_range(0, 3)), rnd(), rnd(), 0); tick();
        drive(0, 0, 2'd0, rnd(), rnd(), 0); tick();
        drive(0, 0, 2'd0, rnd(), rnd(), 0); tick();
        drive(0, 1, 2'($urandom_range(0, 3)), rnd(), rnd(), 0);
        vectors += 2;
        if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bubble_tail_valid: got %b, required 1", out_valid); end
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bubble_in_ready: got %b, required 1", in_ready); end
        tick();
        for (int i = 0; i < D + 2; i++) begin
            drive(0, 0, 2'd0, rnd(), rnd(), 1);
            if (out_valid && out_ready) begin
                vectors++;
                if (exp_q.size() == 0 || out_y !== exp_q[0].y) begin
                    miscompares++; $display("FAIL bubble_out_y: got %h, required %h", out_y, (exp_q.size() > 0) ? exp_q[0].y : '0);
                end
            end
            tick();
        end
        vectors++;
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL bubble_drain: got %0d items left, required 0", exp_q.size()); end
    endtask

    task automatic test_zero_flag();
        logic seen = 1'b0;
        drive(0, 1, 2'd0, 8'hAA, 8'h55, 1); tick();
        for (int i = 0; i < D + 2; i++) begin
            drive(0, 0, 2'd1, 8'hAA, 8'h55, 1);
            vectors++;
            if (out_valid) begin
                seen = 1'b1;
                if (out_y !== 8'h00 || out_zero !== 1'b1) begin miscompares++; $display("FAIL zero_flag: got y %h zero %b, required y 00 zero 1", out_y, out_zero); end
            end else if (out_zero !== 1'b0) begin
                miscompares++; $display("FAIL zero_idle: got %b, required 0", out_zero);
            end
            tick();
        end
        vectors++;
        if (!seen) begin miscompares++; $display("FAIL zero_seen: got no out_valid, required one item"); end
    endtask

    task automatic test_random();
        logic [W-1:0] ey;
        for (int i = 0; i < 400 + D + 2; i++) begin
            if (i < 400)
                drive($urandom_range(0, 49) == 0, $urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)), rnd(), rnd(), $urandom_range(0, 3) != 0);
            else
                drive(0, 0, 2'd0, rnd(), rnd(), 1);
            vectors += 5;
            ey = ref_op(op, a, b);
            if (comb_y !== ey) begin miscompares++; $display("FAIL rand_comb_y: got %h, required %h", comb_y, ey); end
            if (reg_y !== exp_reg_y) begin miscompares++; $display("FAIL rand_reg_y: got %h, required %h", reg_y, exp_reg_y); end
            if (in_ready !== exp_in_ready()) begin miscompares++; $display("FAIL rand_in_ready: got %b, required %b", in_ready, exp_in_ready()); end
            if (busy !== (exp_q.size() != 0)) begin miscompares++; $display("FAIL rand_busy: got %b, required %b", busy, exp_q.size() != 0); end
            if (out_zero !== (out_valid && exp_q.size() > 0 && exp_q[0].y == '0)) begin
                miscompares++; $display("FAIL rand_out_zero: got %b with valid %b", out_zero, out_valid);
            end
            if (exp_q.size() == D && out_valid !== 1'b1) begin
                vectors++; miscompares++; $display("FAIL rand_full_tail: got out_valid %b, required 1", out_valid);
            end
            if (out_valid) begin
                vectors++;
                if (exp_q.size() == 0 || out_y !== exp_q[0].y) begin
                    miscompares++; $display("FAIL rand_out_y: got %h, required %h", out_y, (exp_q.size() > 0) ? exp_q[0].y : '0);
                end
            end
            tick();
        end
        vectors++;
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL rand_drain: got %0d items left, required 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_ops();
        test_back_to_back();
        test_backpressure();
        test_bubble();
        test_zero_flag();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/logic_op_pipe.md
# logic_op_pipe

Parametrised successor to the team's single-bit gate/assignment demonstrator. It applies a selectable bitwise logic operation to two WIDTH-bit operands and presents the result three ways: combinationally, registered every cycle, and through a DEPTH-stage valid/ready pipeline with backpressure and bubble collapsing. It is the reference datapath element for timing/latency experiments on the FPGA board and the template for later handshake-based blocks.

## Interface
- WIDTH, 8: operand and result width in bits (≥1).
- DEPTH, 2: pipeline stages on the handshake path (≥1).
- clk  input  1  sole clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- op  input  2  operation select: 0 AND, 1 OR, 2 XOR, 3 NAND.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- comb_y  output  WIDTH  combinational op(a,b), no state.
- reg_y  output  WIDTH  op(a,b) registered every cycle, independent of handshake.
- in_valid  input  1  upstream offers {op,a,b}.
- in_ready  output  1  pipeline accepts this cycle.
- out_valid  output  1  result available at pipeline tail.
- out_ready  input  1  downstream accepts result.
- out_y  output  WIDTH  pipelined result.
- out_zero  output  1  out_y == 0, qualified by out_valid (0 when out_valid=0).
- busy  output  1  any pipeline stage holds valid data.

## Operation
- Result computed once at stage 0 from op, a, b sampled at acceptance; later changes to op/a/b do not affect accepted items.
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- Each stage k holds {valid_k, data_k}. Stage k may load when empty or when its content leaves this cycle (advance_k = !valid_k | advance_{k+1}; advance_DEPTH = out_ready).
- in_ready = advance_0 & !rst. Ready chain is combinational across stages: full pipeline with out_ready=1 sustains 1 item/cycle.
- Bubbles collapse: a stalled tail does not block upstream stages that are empty.
- out_valid = valid_{DEPTH-1}; out_y = data_{DEPTH-1}; out_y holds stable while out_valid & !out_ready.
- busy = OR of all valid_k.
- No reordering, no drop, no duplication.

## Timing
- comb_y: zero latency.
- reg_y: one cycle after inputs; updates every cycle regardless of in_valid.
- Handshake path: item accepted at edge N appears with out_valid at cycle N+DEPTH when unstalled (DEPTH=1: visible the cycle after acceptance).
- Reset (rst=1 at edge): all valid_k←0, data_k←0, reg_y←0; after reset out_valid=0, out_y=0, out_zero=0, busy=0, reg_y=0. in_ready=0 while rst asserted, 1 the first cycle after.
- Reset mid-operation: all in-flight items discarded; no out_valid in the cycle following reset.
- Simultaneous accept and emit on a full pipeline: both occur, occupancy unchanged.
- out_ready=0 with full pipeline: in_ready=0 in the same cycle; resumes the cycle out_ready returns 1.
- Width: all ops bitwise, result WIDTH bits, no carry or extension.

## Structure
- Package logic_op_pkg: op encodings (OP_AND=2'd0, OP_OR=2'd1, OP_XOR=2'd2, OP_NAND=2'd3) and function logic_op_f(op,a,b) shared by comb_y, reg_y and stage 0.
- Sub-module logic_op_stage: one valid/data register with load/advance logic, instantiated DEPTH times in a generate loop.

## Test plan
- Reset: assert rst 2 cycles mid-stream with 2 items in flight -> out_valid=0, out_y=0, reg_y=0, busy=0, in_ready=0 during rst; no stale item emerges afterwards.
- Ops, WIDTH=8: a=8'hF0, b=8'h3C, op 0..3 -> comb_y 8'h30, 8'hFC, 8'hCC, 8'hCF same cycle; reg_y one cycle later; out_y DEPTH cycles after acceptance.
- Streaming, DEPTH=2, out_ready=1: 16 back-to-back items -> in_ready constant 1, outputs in order at 1/cycle, first out_valid 2 cycles after first accept.
- Backpressure: fill pipeline, hold out_ready=0 5 cycles -> in_ready=0, out_y stable, busy=1; release -> items drain in order, none lost.
- Bubble collapse: one item, stall tail, then in_valid with stage 0 empty -> in_ready=1 and item accepted despite stalled tail.
- Zero flag and op capture: accept a=8'hAA,b=8'h55,op=AND, then change op to OR next cycle -> out_y=8'h00, out_zero=1 when out_valid.
